// File: rtl/rom_line_arbiter.sv
// Multi-channel byte ROM reader: each channel keeps one cached 8-byte line,
// misses share a single 64-bit memory read port through a round-robin arbiter.

module rom_line_lane #(
    parameter int AW = 18
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          flush,
    input  logic          req,
    input  logic [AW-1:0] addr,
    input  logic          issue,
    input  logic          fill,
    input  logic          fill_keep,
    input  logic [63:0]   mem_data,
    output logic [7:0]    dout,
    output logic          rdy,
    output logic          busy,
    output logic          pending,
    output logic [AW-4:0] tag
);
    logic        valid;
    logic        issued;
    logic [63:0] line;
    logic [2:0]  off;
    logic        hit;

    assign hit     = req && !busy && valid && (tag == addr[AW-1:3]) && !flush;
    assign pending = busy && !issued;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            valid  <= 1'b0;
            issued <= 1'b0;
            busy   <= 1'b0;
            rdy    <= 1'b0;
            dout   <= '0;
            line   <= '0;
            off    <= '0;
            tag    <= '0;
        end else begin
            rdy <= 1'b0;
            if (flush) valid <= 1'b0;
            if (issue) issued <= 1'b1;
            if (fill) begin
                line   <= mem_data;
                valid  <= fill_keep;
                busy   <= 1'b0;
                issued <= 1'b0;
                rdy    <= 1'b1;
                dout   <= mem_data[{off, 3'b000} +: 8];
            end else if (req && !busy) begin
                if (hit) begin
                    rdy  <= 1'b1;
                    dout <= line[{addr[2:0], 3'b000} +: 8];
                end else begin
                    // line is being replaced; it only becomes valid again on fill
                    busy  <= 1'b1;
                    tag   <= addr[AW-1:3];
                    off   <= addr[2:0];
                    valid <= 1'b0;
                end
            end
        end
    end
endmodule

module rom_line_arbiter #(
    parameter  int NCH = 2,
    parameter  int AW  = 18,
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              flush,
    input  logic [NCH-1:0]    ch_req,
    input  logic [NCH*AW-1:0] ch_addr,
    output logic [NCH*8-1:0]  ch_dout,
    output logic [NCH-1:0]    ch_rdy,
    output logic [NCH-1:0]    ch_busy,
    output logic [CHW+AW-4:0] mem_addr,
    output logic              mem_req,
    input  logic [63:0]       mem_data,
    input  logic              mem_ready
);
    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t                   state, state_nxt;
    logic [NCH-1:0]           pending;
    logic [NCH-1:0][AW-4:0]   tags;
    logic [CHW-1:0]           ptr, gnt, gsel, idx;
    logic                     found, issue_any, fill_any, flushed;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        issue_any = 1'b0;
        fill_any  = 1'b0;
        gsel      = '0;
        idx       = '0;
        found     = 1'b0;
        for (int k = 1; k <= NCH; k++) begin
            idx = CHW'((int'(ptr) + k) % NCH);
            if (!found && pending[idx]) begin
                found = 1'b1;
                gsel  = idx;
            end
        end
        case (state)
            S_IDLE: if (found) begin
                issue_any = 1'b1;
                state_nxt = S_WAIT;
            end
            S_WAIT: if (mem_ready) begin
                fill_any  = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            ptr      <= CHW'(NCH - 1);
            gnt      <= '0;
            mem_req  <= 1'b0;
            mem_addr <= '0;
            flushed  <= 1'b0;
        end else begin
            mem_req <= issue_any;
            if (issue_any) begin
                ptr      <= gsel;
                gnt      <= gsel;
                mem_addr <= {gsel, tags[gsel]};
                flushed  <= flush;
            end else if (flush) begin
                flushed  <= 1'b1;
            end
        end
    end

    // a fill that saw any flush since its grant is delivered but not cached
    for (genvar i = 0; i < NCH; i++) begin : g_lane
        rom_line_lane #(.AW(AW)) u_lane (
            .clk_sys   (clk_sys),
            .reset     (reset),
            .flush     (flush),
            .req       (ch_req[i]),
            .addr      (ch_addr[i*AW +: AW]),
            .issue     (issue_any && (gsel == CHW'(i))),
            .fill      (fill_any && (gnt == CHW'(i))),
            .fill_keep (!flushed && !flush),
            .mem_data  (mem_data),
            .dout      (ch_dout[i*8 +: 8]),
            .rdy       (ch_rdy[i]),
            .busy      (ch_busy[i]),
            .pending   (pending[i]),
            .tag       (tags[i])
        );
    end
endmodule

// File: tb/tb_rom_line_arbiter.sv
// Bench for rom_line_arbiter: directed vector table, hand-written corner
// sequences, then random traffic against a line-cache reference model.

module tb_rom_line_arbiter;
    localparam int NCH = 2;
    localparam int AW  = 18;
    localparam int CHW = 1;
    localparam int MW  = CHW + AW - 3;

    logic              clk_sys = 1'b0;
    logic              reset, flush;
    logic [NCH-1:0]    ch_req;
    logic [NCH*AW-1:0] ch_addr;
    logic [NCH*8-1:0]  ch_dout;
    logic [NCH-1:0]    ch_rdy, ch_busy;
    logic [MW-1:0]     mem_addr;
    logic              mem_req;
    logic [63:0]       mem_data;
    logic              mem_ready;

    rom_line_arbiter #(.NCH(NCH), .AW(AW)) dut (
        .clk_sys(clk_sys), .reset(reset), .flush(flush),
        .ch_req(ch_req), .ch_addr(ch_addr), .ch_dout(ch_dout),
        .ch_rdy(ch_rdy), .ch_busy(ch_busy), .mem_addr(mem_addr),
        .mem_req(mem_req), .mem_data(mem_data), .mem_ready(mem_ready)
    );

    always #5 clk_sys = ~clk_sys;

    int n_chk = 0, n_fail = 0, mreq_cnt = 0;

    always @(posedge clk_sys) begin
        #1;
        if (mem_req === 1'b1) mreq_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] memf(input logic [MW-1:0] a);
        logic [31:0] x;
        x = {16'h0, a};
        return {(x * 32'h9E3779B1) ^ 32'h5A5A1234, (x ^ 32'h0000FFFF) * 32'h85EBCA6B};
    endfunction

    function automatic logic [7:0] bsel(input logic [63:0] d, input logic [2:0] o);
        return d[{o, 3'b000} +: 8];
    endfunction

    task automatic wait_mreq(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 8; n++) begin
            if (mem_req === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk_sys);
        end
    endtask

    task automatic read1(input string nm, input int ch, input logic [AW-1:0] a,
                         input logic [63:0] ret, input bit fl, input bit miss,
                         input logic [MW-1:0] maddr, input logic [7:0] eb);
        int c0;
        bit ok;
        @(negedge clk_sys);
        ch_req[ch] = 1'b1;
        ch_addr[ch*AW +: AW] = a;
        flush = fl;
        c0 = mreq_cnt;
        @(negedge clk_sys);
        ch_req = '0;
        flush  = 1'b0;
        if (!miss) begin
            chk({nm, " hit_rdy"}, 64'(ch_rdy[ch]), 64'd1);
            chk({nm, " hit_dout"}, 64'(ch_dout[ch*8 +: 8]), 64'(eb));
            chk({nm, " hit_busy"}, 64'(ch_busy[ch]), 64'd0);
            @(negedge clk_sys);
            chk({nm, " hit_no_mreq"}, 64'(mreq_cnt - c0), 64'd0);
        end else begin
            chk({nm, " miss_busy"}, 64'(ch_busy[ch]), 64'd1);
            chk({nm, " miss_no_rdy"}, 64'(ch_rdy[ch]), 64'd0);
            wait_mreq(ok);
            chk({nm, " mreq_seen"}, 64'(ok), 64'd1);
            chk({nm, " mem_addr"}, 64'(mem_addr), 64'(maddr));
            mem_ready = 1'b1;
            mem_data  = ret;
            @(negedge clk_sys);
            mem_ready = 1'b0;
            chk({nm, " fill_rdy"}, 64'(ch_rdy[ch]), 64'd1);
            chk({nm, " fill_dout"}, 64'(ch_dout[ch*8 +: 8]), 64'(eb));
            chk({nm, " fill_busy"}, 64'(ch_busy[ch]), 64'd0);
            chk({nm, " one_mreq"}, 64'(mreq_cnt - c0), 64'd1);
        end
    endtask

    task automatic contend(input string nm, input logic [14:0] t0, input logic [14:0] t1);
        logic [63:0] d0, d1;
        bit ok;
        d0 = memf({1'b0, t0});
        d1 = memf({1'b1, t1});
        @(negedge clk_sys);
        ch_req  = 2'b11;
        ch_addr = {t1, 3'd6, t0, 3'd1};
        @(negedge clk_sys);
        ch_req = '0;
        chk({nm, " both_busy"}, 64'(ch_busy), 64'd3);
        wait_mreq(ok);
        chk({nm, " g0_seen"}, 64'(ok), 64'd1);
        chk({nm, " g0_msb"}, 64'(mem_addr[MW-1]), 64'd0);
        chk({nm, " g0_addr"}, 64'(mem_addr), 64'({1'b0, t0}));
        mem_ready = 1'b1; mem_data = d0;
        @(negedge clk_sys);
        mem_ready = 1'b0;
        chk({nm, " g0_rdy"}, 64'(ch_rdy), 64'd1);
        chk({nm, " g0_dout"}, 64'(ch_dout[7:0]), 64'(bsel(d0, 3'd1)));
        wait_mreq(ok);
        chk({nm, " g1_seen"}, 64'(ok), 64'd1);
        chk({nm, " g1_msb"}, 64'(mem_addr[MW-1]), 64'd1);
        chk({nm, " g1_addr"}, 64'(mem_addr), 64'({1'b1, t1}));
        mem_ready = 1'b1; mem_data = d1;
        @(negedge clk_sys);
        mem_ready = 1'b0;
        chk({nm, " g1_rdy"}, 64'(ch_rdy), 64'd2);
        chk({nm, " g1_dout"}, 64'(ch_dout[15:8]), 64'(bsel(d1, 3'd6)));
    endtask

    typedef struct {
        int          ch;
        logic [17:0] a;
        logic [63:0] ret;
        bit          fl;
        bit          miss;
        logic [15:0] maddr;
        logic [7:0]  eb;
    } vec_t;

    vec_t tbl[9];

    // reference model state for the random phase
    bit          mvalid[NCH], mbusy[NCH], hit_due[NCH];
    logic [14:0] mtag[NCH], ptag[NCH];
    logic [7:0]  expq[NCH][$];

    initial begin
        int c0, misses, md;
        bit ok, mpend;
        logic [AW-1:0] a, b;
        logic [63:0]   d;
        logic [MW-1:0] maddr_l;
        logic [7:0]    eb;

        tbl[0] = '{0, 18'h00013, 64'h8877665544332211, 1'b0, 1'b1, 16'h0002, 8'h44};
        tbl[1] = '{0, 18'h00010, 64'h0,                1'b0, 1'b0, 16'h0000, 8'h11};
        tbl[2] = '{0, 18'h00017, 64'h0,                1'b0, 1'b0, 16'h0000, 8'h88};
        tbl[3] = '{1, 18'h00013, 64'hF0E0D0C0B0A09080, 1'b0, 1'b1, 16'h8002, 8'hB0};
        tbl[4] = '{1, 18'h00014, 64'h0,                1'b0, 1'b0, 16'h0000, 8'hC0};
        tbl[5] = '{0, 18'h3FFF8, 64'h0123456789ABCDEF, 1'b0, 1'b1, 16'h7FFF, 8'hEF};
        tbl[6] = '{0, 18'h3FFFF, 64'h0,                1'b0, 1'b0, 16'h0000, 8'h01};
        tbl[7] = '{0, 18'h00011, 64'h8877665544332211, 1'b0, 1'b1, 16'h0002, 8'h22};
        tbl[8] = '{1, 18'h00012, 64'hF0E0D0C0B0A09080, 1'b1, 1'b1, 16'h8002, 8'hA0};

        reset = 1'b1; flush = 1'b0; ch_req = '0; ch_addr = '0;
        mem_data = '0; mem_ready = 1'b0;
        repeat (3) @(negedge clk_sys);
        chk("rst rdy", 64'(ch_rdy), 64'd0);
        chk("rst busy", 64'(ch_busy), 64'd0);
        chk("rst dout", 64'(ch_dout), 64'd0);
        chk("rst mem_req", 64'(mem_req), 64'd0);
        chk("rst mem_addr", 64'(mem_addr), 64'd0);
        reset = 1'b0;
        @(negedge clk_sys);
        chk("post_rst busy", 64'(ch_busy), 64'd0);

        contend("cont1", 15'h0100, 15'h0101);
        contend("cont2", 15'h0200, 15'h0201);

        foreach (tbl[i])
            read1($sformatf("vec%0d", i), tbl[i].ch, tbl[i].a, tbl[i].ret,
                  tbl[i].fl, tbl[i].miss, tbl[i].maddr, tbl[i].eb);

        // request while busy is dropped
        a = 18'h00A05; b = 18'h01233; d = 64'hDEADBEEFCAFEF00D;
        @(negedge clk_sys);
        ch_req = 2'b10; ch_addr[AW +: AW] = a; c0 = mreq_cnt;
        @(negedge clk_sys);
        chk("busy_ign busy", 64'(ch_busy[1]), 64'd1);
        ch_addr[AW +: AW] = b;
        @(negedge clk_sys);
        ch_req = '0;
        wait_mreq(ok);
        chk("busy_ign seen", 64'(ok), 64'd1);
        chk("busy_ign addr", 64'(mem_addr), 64'({1'b1, a[AW-1:3]}));
        mem_ready = 1'b1; mem_data = d;
        @(negedge clk_sys);
        mem_ready = 1'b0;
        chk("busy_ign rdy", 64'(ch_rdy[1]), 64'd1);
        chk("busy_ign dout", 64'(ch_dout[15:8]), 64'(bsel(d, a[2:0])));
        @(negedge clk_sys);
        chk("busy_ign single_rdy", 64'(ch_rdy[1]), 64'd0);
        repeat (4) @(negedge clk_sys);
        chk("busy_ign one_mreq", 64'(mreq_cnt - c0), 64'd1);

        // flush while the fill is in flight
        a = 18'h02468; d = 64'h1122334455667788;
        @(negedge clk_sys);
        ch_req = 2'b01; ch_addr[0 +: AW] = a;
        @(negedge clk_sys);
        ch_req = '0;
        wait_mreq(ok);
        chk("flush_wait seen", 64'(ok), 64'd1);
        flush = 1'b1;
        @(negedge clk_sys);
        flush = 1'b0; mem_ready = 1'b1; mem_data = d;
        @(negedge clk_sys);
        mem_ready = 1'b0;
        chk("flush_wait rdy", 64'(ch_rdy[0]), 64'd1);
        chk("flush_wait dout", 64'(ch_dout[7:0]), 64'(bsel(d, 3'd0)));
        read1("flush_refetch", 0, a, d, 1'b0, 1'b1, {1'b0, a[AW-1:3]}, bsel(d, 3'd0));
        read1("flush_cached", 0, a | 18'd5, 64'h0, 1'b0, 1'b0, 16'h0, bsel(d, 3'd5));
        read1("flush_hit", 0, a | 18'd2, d, 1'b1, 1'b1, {1'b0, a[AW-1:3]}, bsel(d, 3'd2));

        // reset during WAIT, then a stale mem_ready
        a = 18'h1F0F3; d = 64'hA5A5A5A55A5A5A5A;
        @(negedge clk_sys);
        ch_req = 2'b01; ch_addr[0 +: AW] = a; c0 = mreq_cnt;
        @(negedge clk_sys);
        ch_req = '0;
        wait_mreq(ok);
        chk("rst_wait seen", 64'(ok), 64'd1);
        reset = 1'b1;
        @(negedge clk_sys);
        chk("rst_wait busy", 64'(ch_busy), 64'd0);
        chk("rst_wait mem_req", 64'(mem_req), 64'd0);
        reset = 1'b0;
        @(negedge clk_sys);
        mem_ready = 1'b1; mem_data = d;
        @(negedge clk_sys);
        mem_ready = 1'b0;
        chk("rst_wait no_rdy", 64'(ch_rdy), 64'd0);
        chk("rst_wait no_busy", 64'(ch_busy), 64'd0);
        repeat (3) @(negedge clk_sys);
        chk("rst_wait no_mreq", 64'(mreq_cnt - c0), 64'd1);
        read1("rst_wait invalid", 0, a, d, 1'b0, 1'b1, {1'b0, a[AW-1:3]}, bsel(d, a[2:0]));

        // random traffic against the line-cache model
        reset = 1'b1;
        @(negedge clk_sys);
        reset = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            mvalid[i] = 1'b0; mbusy[i] = 1'b0; hit_due[i] = 1'b0;
            mtag[i] = '0; ptag[i] = '0; expq[i].delete();
        end
        misses = 0; mpend = 1'b0; md = 0; maddr_l = '0;
        c0 = mreq_cnt;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk_sys);
            for (int i = 0; i < NCH; i++) begin
                if (ch_rdy[i]) begin
                    if (expq[i].size() == 0) begin
                        n_chk++; n_fail++;
                        $display("FAIL rnd spurious_rdy ch%0d: got rdy=1 expected rdy=0", i);
                    end else begin
                        eb = expq[i].pop_front();
                        chk($sformatf("rnd dout ch%0d", i), 64'(ch_dout[i*8 +: 8]), 64'(eb));
                        if (hit_due[i]) hit_due[i] = 1'b0;
                        else if (mbusy[i]) begin
                            mbusy[i] = 1'b0; mvalid[i] = 1'b1; mtag[i] = ptag[i];
                        end
                    end
                end else if (hit_due[i]) begin
                    n_chk++; n_fail++;
                    $display("FAIL rnd hit_latency ch%0d: got rdy=0 expected rdy=1", i);
                    hit_due[i] = 1'b0;
                    void'(expq[i].pop_front());
                end
            end
            if (mem_req) begin
                chk("rnd mreq_owner_busy", 64'(mbusy[mem_addr[MW-1]]), 64'd1);
                chk("rnd mreq_tag", 64'(mem_addr[MW-2:0]), 64'(ptag[mem_addr[MW-1]]));
                maddr_l = mem_addr; mpend = 1'b1; md = $urandom_range(0, 3);
            end
            mem_ready = 1'b0;
            if (mpend) begin
                if (md == 0) begin
                    mem_ready = 1'b1; mem_data = memf(maddr_l); mpend = 1'b0;
                end else md--;
            end
            ch_req = '0;
            if (cyc < 2900) begin
                for (int i = 0; i < NCH; i++) begin
                    if ($urandom_range(0, 2) == 0) begin
                        a = {15'($urandom_range(0, 3)), 3'($urandom_range(0, 7))};
                        ch_req[i] = 1'b1;
                        ch_addr[i*AW +: AW] = a;
                        if (!mbusy[i]) begin
                            expq[i].push_back(bsel(memf({1'(i), a[AW-1:3]}), a[2:0]));
                            if (mvalid[i] && mtag[i] == a[AW-1:3]) hit_due[i] = 1'b1;
                            else begin
                                mbusy[i] = 1'b1; ptag[i] = a[AW-1:3]; misses++;
                            end
                        end
                    end
                end
            end
        end
        chk("rnd mreq_count", 64'(mreq_cnt - c0), 64'(misses));
        for (int i = 0; i < NCH; i++)
            chk($sformatf("rnd drained ch%0d", i), 64'(expq[i].size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
